// File: rtl/rc_pulse_meas_if.sv
// rc_pulse_meas_if: RC pulse input and measurement results between a pulse source and the meter.
`timescale 1ns/1ps
interface rc_pulse_meas_if;
   logic        in;
   logic [15:0] pw;
   logic        pw_stb;
   logic        valid;
   logic        err;
   logic        lost;
   modport master (output in, input pw, pw_stb, valid, err, lost);
   modport slave (input in, output pw, pw_stb, valid, err, lost);
endinterface

// File: rtl/rc_pulse_meas.sv
// rc_pulse_meas: measures RC servo pulse high time in usec with range check and signal-loss timeout.
`timescale 1ns/1ps
module rc_pulse_meas #(
   parameter int SYS_CLK    = 50000000,
   parameter int MIN_PW     = 800,
   parameter int MAX_PW     = 2200,
   parameter int TIMEOUT_US = 25000
) (
   input logic             clk,
   input logic             rst_n,
   rc_pulse_meas_if.slave  bus
);
   localparam int DIV = SYS_CLK / 1000000;
   localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
   typedef enum logic [1:0] {ARM, IDLE, HIGH} state_t;
   state_t state, state_nxt;
   logic s1, in_s, in_d, rise, fall, tick, over, accept, reject, lost_n, valid_n;
   logic [1:0] fill;
   logic [DW-1:0] div;
   logic [15:0] hi_cnt, hi_nxt, per_cnt, per_nxt;
   // fill marks when in_s carries a real sample, so ARM cannot mistake reset zeros for a low input
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1   <= 1'b0;
         in_s <= 1'b0;
         in_d <= 1'b0;
         fill <= 2'b00;
      end else begin
         s1   <= bus.in;
         in_s <= s1;
         in_d <= in_s;
         fill <= {fill[0], 1'b1};
      end
   assign rise = in_s & ~in_d;
   assign fall = ~in_s & in_d;
   assign tick = div == DW'(DIV - 1);
   always_comb begin
      hi_nxt  = (tick && state == HIGH && hi_cnt != 16'hFFFF) ? hi_cnt + 16'd1 : hi_cnt;
      per_nxt = (tick && per_cnt != 16'(TIMEOUT_US)) ? per_cnt + 16'd1 : per_cnt;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div     <= '0;
         hi_cnt  <= '0;
         per_cnt <= '0;
      end else begin
         div     <= (rise || tick) ? '0 : div + 1'b1;
         hi_cnt  <= rise ? '0 : hi_nxt;
         per_cnt <= rise ? '0 : per_nxt;
      end
   // hi_nxt includes a tick landing on the fall cycle, giving floor(elapsed usec)
   assign over = state == HIGH && hi_nxt > 16'(MAX_PW);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ARM;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         ARM:     state_nxt = (fill[1] && !in_s) ? IDLE : ARM;
         IDLE:    state_nxt = rise ? HIGH : IDLE;
         HIGH:    state_nxt = over ? ARM : fall ? IDLE : HIGH;
         default: state_nxt = ARM;
      endcase
   end
   always_comb begin
      accept  = state == HIGH && fall && !over && hi_nxt >= 16'(MIN_PW);
      reject  = over || (state == HIGH && fall && hi_nxt < 16'(MIN_PW));
      lost_n  = bus.valid && per_nxt == 16'(TIMEOUT_US);
      valid_n = accept || (bus.valid && !lost_n);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.pw     <= '0;
         bus.pw_stb <= 1'b0;
         bus.valid  <= 1'b0;
         bus.err    <= 1'b0;
         bus.lost   <= 1'b0;
      end else begin
         bus.pw     <= accept ? hi_nxt : bus.pw;
         bus.pw_stb <= accept;
         bus.valid  <= valid_n;
         bus.err    <= reject;
         bus.lost   <= lost_n;
      end
endmodule
